// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two requesters share one combinational IEEE-754
// single-precision adder; round-robin grant, per-port done counters.

module fp_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        swap;
    logic        sub;
    logic        sticky;
    logic        up;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  d;
    logic [23:0] mx;
    logic [23:0] my;
    logic [26:0] ys;
    logic [26:0] mask;
    logic [27:0] s;
    logic [26:0] n;
    logic [4:0]  lz;
    logic [4:0]  sh;
    logic [9:0]  e;
    logic [30:0] pk;

    always_comb begin
        a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
        a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
        b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

        // Order by magnitude so the aligned difference is never negative
        swap = b_i[30:0] > a_i[30:0];
        x    = swap ? b_i : a_i;
        y    = swap ? a_i : b_i;
        ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey   = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx   = {x[30:23] != 8'd0, x[22:0]};
        my   = {y[30:23] != 8'd0, y[22:0]};
        d    = ex - ey;
        sub  = x[31] ^ y[31];

        mask = '0;
        if (d >= 8'd27) begin
            ys     = '0;
            sticky = (my != 24'd0);
        end else begin
            mask   = (27'd1 << d[4:0]) - 27'd1;
            ys     = {my, 3'b000} >> d[4:0];
            sticky = |({my, 3'b000} & mask);
        end
        ys[0] = ys[0] | sticky;

        s = sub ? ({1'b0, mx, 3'b000} - {1'b0, ys})
                : ({1'b0, mx, 3'b000} + {1'b0, ys});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end

        e  = {2'b00, ex};
        sh = '0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // Never normalise below the minimum exponent: gradual underflow
            sh = ({5'd0, lz} < e) ? lz : 5'(e - 10'd1);
            n  = s[26:0] << sh;
            e  = e - {5'd0, sh};
        end

        pk = {(n[26] ? e[7:0] : 8'd0), n[25:3]};
        up = n[2] & (n[1] | n[0] | n[3]);

        if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31])))
            sum_o = 32'h7FC0_0000;
        else if (a_inf)
            sum_o = a_i;
        else if (b_inf)
            sum_o = b_i;
        else if (s == 28'd0)
            sum_o = {x[31] & y[31], 31'd0};
        else if (e >= 10'd255)
            sum_o = {x[31], 8'hFF, 23'd0};
        else
            sum_o = {x[31], pk + {30'd0, up}};
    end
endmodule

module fp_add_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid0,
    input  logic             req_valid1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b1,
    output logic             req_ready0,
    output logic             req_ready1,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    input  logic             rsp_ready0,
    input  logic             rsp_ready1,
    output logic [31:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             tag_q, tag_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      res_q, res_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [31:0]      sum;
    logic             grant;

    fp_adder u_add (
        .a_i  (a_q),
        .b_i  (b_q),
        .sum_o(sum)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        tag_d      = tag_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        rsp_valid0 = 1'b0;
        rsp_valid1 = 1'b0;

        grant      = (req_valid0 && req_valid1) ? ~last_q : req_valid1;
        req_ready0 = (state_q == IDLE) && req_valid0 && !grant;
        req_ready1 = (state_q == IDLE) && req_valid1 && grant;

        unique case (state_q)
            IDLE: begin
                if (req_ready0 || req_ready1) begin
                    a_d     = req_ready1 ? req_a1 : req_a0;
                    b_d     = req_ready1 ? req_b1 : req_b0;
                    tag_d   = req_ready1;
                    last_d  = req_ready1;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = sum;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid0 = !tag_q;
                rsp_valid1 = tag_q;
                if (tag_q ? rsp_ready1 : rsp_ready0) begin
                    if (tag_q) cnt1_d = cnt1_q + ONE;
                    else       cnt0_d = cnt0_q + ONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            tag_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign rsp_data  = res_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;
endmodule
